// File: rtl/gzip_reg_bank.sv
// gzip_reg_bank: byte-wide control/event/status/ID register bank with scratch RAM for the GZIP core
module gzip_reg_bank #(
  parameter int          ADDR_W    = 5,
  parameter int          NUM_CTRL  = 2,
  parameter int          NUM_STAT  = 12,
  parameter logic [7:0]  DEVICE_ID = 8'hB9,
  parameter logic [7:0]  VERSION   = 8'h02
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       reg_addr,
  input  logic                    reg_wren,
  input  logic [7:0]              reg_wdata,
  input  logic                    reg_rden,
  output logic [7:0]              reg_rdata,
  output logic [8*NUM_CTRL-1:0]   ctrl_o,
  output logic                    start_o,
  input  logic [7:0]              evt_i,
  output logic                    irq_o,
  input  logic [8*NUM_STAT-1:0]   stat_i
);
  localparam int MAP  = 1 << ADDR_W;
  localparam int SB_I = NUM_CTRL + 2;
  localparam int ID_I = SB_I + NUM_STAT;
  localparam int SCR_I = ID_I + 2;
  localparam logic [ADDR_W-1:0] EVT_A  = ADDR_W'(NUM_CTRL);
  localparam logic [ADDR_W-1:0] MASK_A = ADDR_W'(NUM_CTRL + 1);
  localparam logic [ADDR_W-1:0] SB_A   = ADDR_W'(SB_I);
  localparam logic [ADDR_W-1:0] ID_A   = ADDR_W'(ID_I);
  localparam logic [ADDR_W-1:0] VER_A  = ADDR_W'(ID_I + 1);

  if (NUM_CTRL < 1 || NUM_STAT < 1 || NUM_CTRL + NUM_STAT + 4 > MAP) begin : g_bad_map
    $error("gzip_reg_bank: register map does not fit in 2**ADDR_W bytes");
  end

  logic [NUM_CTRL-1:0][7:0] ctrl_q;
  logic [NUM_STAT-1:0][7:0] shadow;
  logic [7:0]               evt_q;
  logic [7:0]               mask_q;
  logic [7:0]               scr [MAP];
  logic [7:0]               rd_val;
  logic                     wr_evt;
  logic                     scr_hit;
  logic                     snap;

  assign ctrl_o  = ctrl_q;
  assign wr_evt  = reg_wren && reg_addr == EVT_A;
  assign scr_hit = 32'(reg_addr) >= SCR_I;
  assign snap    = reg_rden && reg_addr == SB_A;

  // read mux; the base status byte comes live from stat_i, the rest from the snapshot
  always_comb begin
    rd_val = 8'h00;
    for (int k = 0; k < NUM_CTRL; k++)
      if (reg_addr == ADDR_W'(k)) rd_val = ctrl_q[k];
    for (int k = 0; k < NUM_STAT; k++)
      if (reg_addr == ADDR_W'(SB_I + k)) rd_val = (k == 0) ? stat_i[7:0] : shadow[k];
    rd_val = (reg_addr == EVT_A)  ? evt_q     : rd_val;
    rd_val = (reg_addr == MASK_A) ? mask_q    : rd_val;
    rd_val = (reg_addr == ID_A)   ? DEVICE_ID : rd_val;
    rd_val = (reg_addr == VER_A)  ? VERSION   : rd_val;
    rd_val = scr_hit              ? scr[reg_addr] : rd_val;
  end

  // control bytes; CTRL0 bit1 is a strobe that is never stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      start_o <= 1'b0;
    end else begin
      start_o <= reg_wren && reg_addr == ADDR_W'(0) && reg_wdata[1];
      for (int k = 0; k < NUM_CTRL; k++)
        if (reg_wren && reg_addr == ADDR_W'(k)) ctrl_q[k] <= (k == 0) ? (reg_wdata & 8'hFD) : reg_wdata;
    end
  end

  // sticky W1C events, mask and registered interrupt; a same-cycle event beats the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q  <= 8'h00;
      mask_q <= 8'h00;
      irq_o  <= 1'b0;
    end else begin
      evt_q  <= (evt_q & ~(wr_evt ? reg_wdata : 8'h00)) | evt_i;
      mask_q <= (reg_wren && reg_addr == MASK_A) ? reg_wdata : mask_q;
      irq_o  <= |(evt_q & mask_q);
    end
  end

  // status snapshot taken on a read of the base byte, plus the read data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      reg_rdata <= 8'h00;
    end else begin
      shadow    <= snap ? stat_i : shadow;
      reg_rdata <= reg_rden ? rd_val : reg_rdata;
    end
  end

  // scratch RAM, deliberately not reset
  always_ff @(posedge clk) begin
    if (reg_wren && scr_hit) scr[reg_addr] <= reg_wdata;
  end
endmodule

// File: tb/tb_gzip_reg_bank.sv
// tb_gzip_reg_bank: scoreboard bench for gzip_reg_bank
module tb_gzip_reg_bank;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  reg_addr;
  logic        reg_wren;
  logic [7:0]  reg_wdata;
  logic        reg_rden;
  logic [7:0]  reg_rdata;
  logic [15:0] ctrl_o;
  logic        start_o;
  logic [7:0]  evt_i;
  logic        irq_o;
  logic [95:0] stat_i;
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_q [$];
  logic [4:0]  adr_q [$];
  logic        pend;

  gzip_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .reg_wren(reg_wren),
    .reg_wdata(reg_wdata), .reg_rden(reg_rden), .reg_rdata(reg_rdata),
    .ctrl_o(ctrl_o), .start_o(start_o), .evt_i(evt_i), .irq_o(irq_o), .stat_i(stat_i)
  );

  always #5 clk = ~clk;

  // tracks which edges captured a read
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pend <= 1'b0;
    else pend <= reg_rden;

  // pops the scoreboard when read data is due
  always @(negedge clk) begin
    logic [7:0] e;
    logic [4:0] a;
    if (pend) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected got %h, scoreboard empty", reg_rdata);
      end else begin
        e = exp_q.pop_front();
        a = adr_q.pop_front();
        if (reg_rdata !== e) begin
          fails++;
          $display("FAIL rd_addr_%0d got %h exp %h", a, reg_rdata, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    reg_addr = a; reg_wdata = d; reg_wren = 1'b1;
    @(negedge clk);
    reg_wren = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] e);
    exp_q.push_back(e); adr_q.push_back(a);
    reg_addr = a; reg_rden = 1'b1;
    @(negedge clk);
    reg_rden = 1'b0;
  endtask

  task automatic rw(input logic [4:0] a, input logic [7:0] d, input logic [7:0] e);
    exp_q.push_back(e); adr_q.push_back(a);
    reg_addr = a; reg_wdata = d; reg_wren = 1'b1; reg_rden = 1'b1;
    @(negedge clk);
    reg_wren = 1'b0; reg_rden = 1'b0;
  endtask

  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] e);
    tests++;
    if (got !== e) begin
      fails++;
      $display("FAIL %s got %h exp %h", n, got, e);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; reg_addr = '0; reg_wren = 1'b0; reg_wdata = '0; reg_rden = 1'b0;
    evt_i = '0; stat_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ctrl", ctrl_o, 16'h0000);
    chk("rst_irq", {15'd0, irq_o}, 16'd0);
    chk("rst_start", {15'd0, start_o}, 16'd0);
    chk("rst_rdata", {8'd0, reg_rdata}, 16'd0);
    for (int a = 0; a < 16; a++) rd(5'(a), 8'h00);
    rd(5'd16, 8'hB9);
    rd(5'd17, 8'h02);
  endtask

  task automatic test_ctrl;
    wr(5'd0, 8'h03);
    chk("ctrl0_val", {8'd0, ctrl_o[7:0]}, 16'h0001);
    chk("start_hi", {15'd0, start_o}, 16'd1);
    @(negedge clk);
    chk("start_lo", {15'd0, start_o}, 16'd0);
    rd(5'd0, 8'h01);
    wr(5'd1, 8'hA5);
    chk("ctrl1_val", {8'd0, ctrl_o[15:8]}, 16'h00A5);
    rd(5'd1, 8'hA5);
  endtask

  task automatic test_evt;
    evt_i = 8'h05;
    @(negedge clk);
    evt_i = 8'h00;
    wr(5'd3, 8'h04);
    chk("irq_lag", {15'd0, irq_o}, 16'd0);
    @(negedge clk);
    chk("irq_set", {15'd0, irq_o}, 16'd1);
    rd(5'd2, 8'h05);
    rd(5'd3, 8'h04);
    wr(5'd2, 8'h04);
    chk("irq_clr_lag", {15'd0, irq_o}, 16'd1);
    @(negedge clk);
    chk("irq_clr", {15'd0, irq_o}, 16'd0);
    rd(5'd2, 8'h01);
    evt_i = 8'h04;
    wr(5'd2, 8'h04);
    evt_i = 8'h00;
    rd(5'd2, 8'h05);
    chk("irq_set_wins", {15'd0, irq_o}, 16'd1);
    rw(5'd2, 8'h05, 8'h05);
    rd(5'd2, 8'h00);
    wr(5'd3, 8'h00);
    chk("irq_final", {15'd0, irq_o}, 16'd0);
  endtask

  task automatic test_status;
    stat_i = 96'h0123_4567_89AB_CDEF_A1B2_C3D4;
    rd(5'd4, 8'hD4);
    stat_i = 96'hFFEE_DDCC_BBAA_9988_7766_5544;
    rd(5'd5, 8'hC3);
    rd(5'd6, 8'hB2);
    rd(5'd7, 8'hA1);
    rd(5'd15, 8'h01);
    rd(5'd4, 8'h44);
    rd(5'd5, 8'h55);
  endtask

  task automatic test_scratch;
    wr(5'd18, 8'h11);
    rw(5'd18, 8'h5A, 8'h11);
    rd(5'd18, 8'h5A);
    wr(5'd31, 8'hC7);
    rd(5'd31, 8'hC7);
    rd(5'd18, 8'h5A);
  endtask

  task automatic test_ignored_reset;
    wr(5'd16, 8'hFF);
    wr(5'd17, 8'hFF);
    wr(5'd6, 8'hFF);
    rd(5'd16, 8'hB9);
    rd(5'd17, 8'h02);
    rd(5'd6, 8'h66);
    wr(5'd3, 8'hFF);
    evt_i = 8'h01;
    @(negedge clk);
    evt_i = 8'h00;
    @(negedge clk);
    chk("irq_pre_rst", {15'd0, irq_o}, 16'd1);
    wr(5'd0, 8'h02);
    chk("start_pre_rst", {15'd0, start_o}, 16'd1);
    reg_addr = 5'd1; reg_wdata = 8'h77; reg_wren = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", ctrl_o, 16'h0000);
    chk("mid_rst_start", {15'd0, start_o}, 16'd0);
    chk("mid_rst_irq", {15'd0, irq_o}, 16'd0);
    chk("mid_rst_rdata", {8'd0, reg_rdata}, 16'd0);
    @(negedge clk);
    reg_wren = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    rd(5'd2, 8'h00);
    rd(5'd3, 8'h00);
    rd(5'd1, 8'h00);
    rd(5'd7, 8'h00);
  endtask

  initial begin
    test_reset;
    test_ctrl;
    test_evt;
    test_status;
    test_scratch;
    test_ignored_reset;
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
